capp_search_engine: RTL and testbench

- Parametrised, sequential successor to the single-shot masked compare array of the content-addressable parallel processor (CAPP).
- Holds DEPTH words of WIDTH bits, each with a valid bit, and executes word write, masked search, tag-intersecting search and masked multi-write on tagged words.
- Sweeps LANES words per clock under a command valid/ready handshake.
- Publishes the tag vector plus first-responder index; sits between the host command interface and CAPP result logic on the TinyFPGA BX.

---
 rtl/capp_pkg.sv | 19 +
 rtl/capp_first_responder.sv | 38 +++
 rtl/capp_search_engine.sv | 130 +++++++++++++
 tb/tb_capp_search_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/capp_pkg.sv
// capp_pkg: shared op codes and FSM states for the CAPP search engine family.
// Latency: n/a (types only).
// Backpressure: n/a.
package capp_pkg;

  typedef enum logic [1:0] {
    CAPP_OP_WRITE      = 2'd0,
    CAPP_OP_SEARCH     = 2'd1,
    CAPP_OP_SEARCH_AND = 2'd2,
    CAPP_OP_MULTIWRITE = 2'd3
  } capp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } capp_state_e;

endpackage

// File: rtl/capp_first_responder.sv
// capp_first_responder: lowest-index priority encoder over the tag vector.
// Latency: combinational.
// Backpressure: none; outputs follow tags directly.
// Optional: CAPP_MATCH_COUNT_EN adds match_count, the popcount of tags.
module capp_first_responder #(
  parameter int DEPTH = 64
) (
  input  logic [DEPTH-1:0]         tags,
  output logic                     any_match,
  output logic [$clog2(DEPTH)-1:0] first_idx
`ifdef CAPP_MATCH_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0]   match_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    any_match = |tags;
    first_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tags[i]) first_idx = AW'(i);
    end
  end

`ifdef CAPP_MATCH_COUNT_EN
  // Popcount of the tag register.
  always_comb begin
    match_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_count = match_count + (AW + 1)'(tags[i]);
    end
  end
`endif

endmodule

// File: rtl/capp_search_engine.sv
// capp_search_engine: DEPTH-word store with masked search, tag-AND search and masked multiwrite.
// Latency: WRITE done 2 cycles after accept; other ops done DEPTH/LANES+1 cycles after accept.
// Backpressure: cmd_ready high only in IDLE; cmd_valid elsewhere is ignored, nothing is queued.
// Optional: define CAPP_MATCH_COUNT_EN to add the match_count output.
module capp_search_engine
  import capp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int LANES = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [$clog2(DEPTH)-1:0] cmd_addr,
  input  logic [WIDTH-1:0]         cmd_data,
  input  logic [WIDTH-1:0]         cmd_mask,
  output logic                     done,
  output logic [DEPTH-1:0]         tags,
  output logic                     any_match,
  output logic [$clog2(DEPTH)-1:0] first_idx
`ifdef CAPP_MATCH_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0]   match_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = DEPTH / LANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  capp_state_e      state_q, state_d;
  capp_op_e         op_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] data_q, mask_q;
  logic [BW-1:0]    bank_q;
  logic             last_bank;
  logic             accept;
  logic [DEPTH-1:0] tags_q, valid_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    lane_idx [LANES];
  logic [LANES-1:0] lane_hit;

  assign cmd_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign last_bank = (bank_q == BW'(NB - 1));
  assign tags      = tags_q;

  // Next-state logic: WRITE needs one BUSY cycle, the sweeping ops need one per bank.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = BUSY;
      BUSY:    if (op_q == CAPP_OP_WRITE || last_bank) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word indices covered by the current bank and their masked-compare result.
  always_comb begin
    lane_hit = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = AW'(int'(bank_q) * LANES + l);
      lane_hit[l] = valid_q[lane_idx[l]] &&
                    (((mem[lane_idx[l]] ^ data_q) & mask_q) == '0);
    end
  end

  // Control state, bank counter, tags and valid bits; reset clears all of them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      bank_q  <= '0;
      tags_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == BUSY && op_q != CAPP_OP_WRITE) begin
        bank_q <= last_bank ? '0 : bank_q + 1'b1;
      end
      if (state_q == BUSY) begin
        case (op_q)
          CAPP_OP_WRITE: valid_q[addr_q] <= 1'b1;
          CAPP_OP_SEARCH: begin
            for (int l = 0; l < LANES; l++) tags_q[lane_idx[l]] <= lane_hit[l];
          end
          CAPP_OP_SEARCH_AND: begin
            for (int l = 0; l < LANES; l++)
              tags_q[lane_idx[l]] <= tags_q[lane_idx[l]] & lane_hit[l];
          end
          default: ;
        endcase
      end
    end
  end

  // Command latch and word storage; storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      op_q   <= capp_op_e'(cmd_op);
      addr_q <= cmd_addr;
      data_q <= cmd_data;
      mask_q <= cmd_mask;
    end
    if (state_q == BUSY && op_q == CAPP_OP_WRITE) begin
      mem[addr_q] <= data_q;
    end
    if (state_q == BUSY && op_q == CAPP_OP_MULTIWRITE) begin
      for (int l = 0; l < LANES; l++) begin
        if (tags_q[lane_idx[l]])
          mem[lane_idx[l]] <= (mem[lane_idx[l]] & ~mask_q) | (data_q & mask_q);
      end
    end
  end

  capp_first_responder #(.DEPTH(DEPTH)) u_first_responder (
    .tags        (tags_q),
    .any_match   (any_match),
    .first_idx   (first_idx)
`ifdef CAPP_MATCH_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

endmodule

// File: tb/tb_capp_search_engine.sv
// tb_capp_search_engine: directed table, back-to-back, mid-op reset and random checks
// against an array-level reference model of the CAPP search engine (WIDTH=8, DEPTH=16, LANES=4).
module tb_capp_search_engine;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int L  = 4;
  localparam int NB = D / L;
  localparam logic [1:0] OP_WR = 2'd0, OP_S = 2'd1, OP_SA = 2'd2, OP_MW = 2'd3;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic [3:0]   cmd_addr = 4'd0;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] cmd_mask = '0;
  logic         done;
  logic [D-1:0] tags;
  logic         any_match;
  logic [3:0]   first_idx;
`ifdef CAPP_MATCH_COUNT_EN
  logic [4:0]   match_count;
`endif

  always #5 CLK = ~CLK;

  capp_search_engine #(.WIDTH(W), .DEPTH(D), .LANES(L)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .done(done), .tags(tags), .any_match(any_match), .first_idx(first_idx)
`ifdef CAPP_MATCH_COUNT_EN
    , .match_count(match_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: whole-array state after each completed command.
  logic [W-1:0] mem_m [D];
  logic [D-1:0] valid_m = '0;
  logic [D-1:0] tags_m = '0;

  typedef struct {
    logic [1:0]   op;
    logic [3:0]   addr;
    logic [W-1:0] data;
    logic [W-1:0] mask;
    logic [D-1:0] exp_tags;
    logic [3:0]   exp_first;
  } vec_t;

  typedef struct {
    logic [1:0]   op;
    logic [3:0]   addr;
    logic [W-1:0] data;
    logic [W-1:0] mask;
  } cmd_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] lowest_set(input logic [D-1:0] t);
    for (int i = 0; i < D; i++) if (t[i]) return 4'(i);
    return 4'd0;
  endfunction

  // Apply one command to the model using the architectural rules directly.
  task automatic model_apply(input cmd_t c);
    logic [D-1:0] hit;
    for (int i = 0; i < D; i++)
      hit[i] = valid_m[i] && (((mem_m[i] ^ c.data) & c.mask) == 8'h00);
    case (c.op)
      OP_WR: begin mem_m[c.addr] = c.data; valid_m[c.addr] = 1'b1; end
      OP_S:  tags_m = hit;
      OP_SA: tags_m = tags_m & hit;
      default: begin
        for (int i = 0; i < D; i++)
          if (tags_m[i]) mem_m[i] = (mem_m[i] & ~c.mask) | (c.data & c.mask);
      end
    endcase
  endtask

  task automatic chk_result(input string name, input logic [D-1:0] exp_t, input logic [3:0] exp_f);
    chk({name, "_tags"}, 32'(tags), 32'(exp_t));
    chk({name, "_any"}, 32'(any_match), 32'(exp_t != '0));
    chk({name, "_first"}, 32'(first_idx), 32'(exp_f));
`ifdef CAPP_MATCH_COUNT_EN
    chk({name, "_count"}, 32'(match_count), 32'($countones(exp_t)));
`endif
  endtask

  task automatic drive(input cmd_t c);
    cmd_op = c.op; cmd_addr = c.addr; cmd_data = c.data; cmd_mask = c.mask;
  endtask

  // Issue one command, check done latency and pulse width, update the model.
  task automatic do_cmd(input string name, input cmd_t c);
    int n;
    @(negedge CLK);
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge CLK); n++; end
    if (!cmd_ready) chk({name, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
    drive(c);
    cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    n = 1;
    while (!done && n < 20) begin @(negedge CLK); n++; end
    chk({name, "_latency"}, 32'(n), (c.op == OP_WR) ? 32'd2 : 32'(NB + 1));
    model_apply(c);
    @(negedge CLK);
    chk({name, "_done_width"}, 32'(done), 32'd0);
  endtask

  vec_t vecs[12];
  cmd_t seq[4];
  int   acc[4];

  initial begin
    cmd_t c;
    int k, dones, ready_hi;

    // Reset state.
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk_result("rst", 16'h0000, 4'd0);
    RST = 1'b0;

    // Directed vectors: op, addr, data, mask, expected tags, expected first index.
    vecs[0]  = '{OP_S,  4'd0,  8'h00, 8'h00, 16'h0000, 4'd0};
    vecs[1]  = '{OP_WR, 4'd3,  8'hA5, 8'h00, 16'h0000, 4'd0};
    vecs[2]  = '{OP_WR, 4'd7,  8'hA4, 8'h00, 16'h0000, 4'd0};
    vecs[3]  = '{OP_WR, 4'd12, 8'h15, 8'h00, 16'h0000, 4'd0};
    vecs[4]  = '{OP_S,  4'd0,  8'hA5, 8'hFF, 16'h0008, 4'd3};
    vecs[5]  = '{OP_S,  4'd0,  8'hA5, 8'hFE, 16'h0088, 4'd3};
    vecs[6]  = '{OP_S,  4'd0,  8'h05, 8'h0F, 16'h1008, 4'd3};
    vecs[7]  = '{OP_SA, 4'd0,  8'h80, 8'h80, 16'h0008, 4'd3};
    vecs[8]  = '{OP_S,  4'd0,  8'hA5, 8'hFE, 16'h0088, 4'd3};
    vecs[9]  = '{OP_MW, 4'd0,  8'h0F, 8'h0F, 16'h0088, 4'd3};
    vecs[10] = '{OP_S,  4'd0,  8'hAF, 8'hFF, 16'h0088, 4'd3};
    vecs[11] = '{OP_S,  4'd0,  8'h15, 8'hFF, 16'h1000, 4'd12};
    for (int i = 0; i < 12; i++) begin
      c = '{vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask};
      do_cmd($sformatf("vec%0d", i), c);
      chk_result($sformatf("vec%0d", i), vecs[i].exp_tags, vecs[i].exp_first);
    end

    // cmd_valid held high with alternating ops: accepts only in IDLE, spacing = done latency + 1.
    seq[0] = '{OP_WR, 4'd5, 8'h3C, 8'h00};
    seq[1] = '{OP_S,  4'd0, 8'h3C, 8'hFF};
    seq[2] = '{OP_WR, 4'd9, 8'h3C, 8'h00};
    seq[3] = '{OP_S,  4'd0, 8'h3C, 8'hFF};
    k = 0; dones = 0; ready_hi = 0;
    @(negedge CLK);
    drive(seq[0]);
    cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 80 && dones < 4; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      if (done) dones++;
      if (cmd_ready) ready_hi++;
      if (cmd_ready && k < 4) begin
        acc[k] = cyc;
        model_apply(seq[k]);
        k++;
        @(posedge CLK);
        #1;
        if (k < 4) drive(seq[k]); else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", 32'(k), 32'd4);
    chk("b2b_dones", 32'(dones), 32'd4);
    chk("b2b_ready_cycles", 32'(ready_hi), 32'd4);
    chk("b2b_gap_write", 32'(acc[1] - acc[0]), 32'd3);
    chk("b2b_gap_search", 32'(acc[2] - acc[1]), 32'(NB + 2));
    chk("b2b_gap_write2", 32'(acc[3] - acc[2]), 32'd3);
    chk("b2b_model_tags", 32'(tags_m), 32'h0220);
    @(negedge CLK);
    chk_result("b2b", tags_m, lowest_set(tags_m));

    // Randomised commands against the model.
    for (int i = 0; i < 40; i++) begin
      c.op   = (i < 6) ? OP_WR : 2'($urandom_range(0, 3));
      c.addr = 4'($urandom_range(0, D - 1));
      c.data = {4'($urandom_range(1, 2)), 4'($urandom_range(1, 2))};
      c.mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      do_cmd($sformatf("rnd%0d", i), c);
      chk_result($sformatf("rnd%0d", i), tags_m, lowest_set(tags_m));
    end

    // Reset during bank 2 of a SEARCH: back to IDLE with cleared tags and no done.
    @(negedge CLK);
    drive('{OP_S, 4'd0, 8'h00, 8'h00});
    cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    valid_m = '0;
    tags_m = '0;
    chk("rstmid_ready", 32'(cmd_ready), 32'd1);
    chk("rstmid_done", 32'(done), 32'd0);
    chk_result("rstmid", 16'h0000, 4'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (done) dones++;
    end
    chk("rstmid_no_done", 32'(dones), 32'd0);
    do_cmd("post_rst", '{OP_S, 4'd0, 8'h00, 8'h00});
    chk_result("post_rst", 16'h0000, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
